count_enable_ctrl: RTL and testbench
====================================

# count_enable_ctrl

Run/step/halt controller that generates the `enable` strobe for the 8-bit binary counter (`b_counter`) directly downstream. It turns operator-level controls into clean single-cycle enable pulses:
- free-running at a programmable prescaled rate;
- one pulse per step request;
- forced stop on halt.

`enable` is registered so the counter sees a glitch-free, clock-aligned strobe.

## Interface
- `PRESCALE_W`, 8: width of the prescale input and internal prescale counter.
- `DEBOUNCE_CYCLES`, 4: consecutive stable samples required on `step`. Used only when `STEP_DEBOUNCE_EN` is defined; legal range 1–255.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  level; requests free-running mode.
- `step`  in  1  level; each low→high transition requests one enable pulse while idle.
- `halt`  in  1  level; forces the HALT state. Has priority over `run` and `step`.
- `prescale`  in  PRESCALE_W  in RUN, one pulse every `prescale`+1 cycles. Sampled every cycle.
- `enable`  out  1  registered one-cycle strobe to the counter's `enable`.
- `running`  out  1  high while in RUN.
- `halted`  out  1  high while in HALT.

## Operation
- **State set:** IDLE, STEP, RUN, HALT.
- **Reset values:** state IDLE, `enable`=0, `running`=0, `halted`=0, prescale counter `pre_cnt`=0. The step history register `step_d` resets to 1, so a `step` held high through reset produces no pulse.
- **Rising-edge detect:** `step_rise` = `step` & ~`step_d`. `step_d` updates every cycle in every state.
- **Halt priority:** `halt`=1 in any state → next state HALT, `enable`←0, `pre_cnt`←0.
- **IDLE:**
  - `run`=1 → RUN, `pre_cnt`←0.
  - Else `step_rise` → STEP, `enable`←1.
  - `run` wins over a simultaneous `step_rise`, and that step is discarded.
- **STEP:** lasts exactly one cycle. `enable` is high during it. Next state IDLE, `enable`←0.
- **RUN:**
  - `run`=0 → IDLE, `enable`←0, `pre_cnt`←0.
  - Else if `pre_cnt` ≥ `prescale`: `enable`←1, `pre_cnt`←0.
  - Else `enable`←0, `pre_cnt`←`pre_cnt`+1.
  - `step` is ignored in RUN.
- **HALT:** `enable` held 0. Exits to IDLE only when `halt`=0 and `run`=0 in the same cycle, so a still-asserted `run` cannot auto-restart.
- **Counter arithmetic:** the ≥ compare means lowering `prescale` below the current `pre_cnt` fires on the next edge; `pre_cnt` never wraps. `pre_cnt` is unsigned, PRESCALE_W bits.
- **Output decode:** `running` and `halted` are decoded from the state register (no extra latency).

## Timing
- **Step latency:** `step_rise` sampled at edge k → `enable`=1 from edge k to edge k+1 → counter increments at edge k+1. Pulse width is exactly 1 cycle.
- **RUN entry and rate:** RUN entered at edge k → first `enable` asserted after edge k+1+`prescale`. Pulses then repeat every `prescale`+1 cycles. With `prescale`=0, `enable` stays high every cycle in RUN.
- **Run release:** `run` falling while `enable`=1 → `enable` low after the next edge; no extra pulse.
- **Halt latency:** `halt` sampled at edge k → `enable`=0 and `halted`=1 after edge k.
- **Reset mid-operation:** takes effect at the next edge regardless of state. Any pulse in flight is cut at that edge.
- **Step throughput:** a new step can fire once per 2 cycles at most (IDLE→STEP→IDLE). Held `step` yields one pulse only.

## Configuration
- **`STEP_DEBOUNCE_EN` defined:**
  - `step` passes through a 2-flop synchronizer, then a stability filter. The filtered value changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
  - Edge detection uses the filtered value.
  - Synchronizer and filter reset to 1.
  - Step latency grows by 2+DEBOUNCE_CYCLES cycles.
  - Bounces shorter than DEBOUNCE_CYCLES produce no pulse.
- **Not defined:** `step` is treated as synchronous to `clk`. No synchronizer or filter logic is instantiated; latency is as in Timing.

## Test plan
- **Reset with step held:** `reset`=1 for 2 cycles with `step`=1, then release with `step` still 1 → `enable`, `running`, `halted` all 0 for 10 cycles.
- **Single step:** `step` 0→1 held 10 cycles in IDLE → exactly one `enable` pulse, 1 cycle wide, asserted the cycle after the rise is sampled. Downstream counter goes 0x00→0x01.
- **Prescaled run:** `prescale`=3, `run`=1 for 20 edges → 5 pulses spaced 4 cycles apart, `running`=1 throughout. `run`=0 → `enable`=0 and `running`=0 within 1 cycle.
- **Full-rate run:** `prescale`=0, `run`=1 for 256 cycles → `enable` high continuously after the entry cycle. Downstream counter wraps 0xFF→0x00.
- **Halt behaviour:** `halt`=1 mid-run with `run`=1 → `enable`=0 and `halted`=1 next cycle. Dropping `halt` with `run` still 1 → stays HALT. Dropping `run` → IDLE next cycle, no pulse.
- **Prescale change mid-run:** `prescale` changed 10→2 while `pre_cnt`=7 → `enable` fires on the next edge, then every 3 cycles.

Source files
------------

// File: rtl/count_enable_ctrl.sv
// -----------------------------------------------------------------------------
// count_enable_ctrl
//   Run/step/halt controller that produces the registered one-cycle enable
//   strobe for the downstream 8-bit binary counter.
//
//   Modes:
//     IDLE : waiting; a step rising edge fires a single pulse, run starts RUN.
//     STEP : one-cycle state during which enable is high.
//     RUN  : free-running, one pulse every prescale+1 cycles.
//     HALT : enable forced low; leaves only when halt and run are both low.
//
//   Optional feature (macro STEP_DEBOUNCE_EN):
//     step goes through a 2-flop synchronizer and a stability filter that
//     changes only after DEBOUNCE_CYCLES consecutive identical samples.
//     Without the macro, step is assumed synchronous to clk.
//
//   Parameters:
//     PRESCALE_W      width of prescale input and internal prescale counter
//     DEBOUNCE_CYCLES stable samples required on step (debounce build, 1..255)
//
//   Ports:
//     clk       in   clock, all logic on posedge
//     reset     in   synchronous active-high reset
//     run       in   level, requests free-running mode
//     step      in   level, each rising edge requests one pulse while idle
//     halt      in   level, forces HALT; priority over run and step
//     prescale  in   RUN pulse period minus one, sampled every cycle
//     enable    out  registered one-cycle strobe to the counter
//     running   out  high while in RUN
//     halted    out  high while in HALT
// -----------------------------------------------------------------------------
module count_enable_ctrl #(
    parameter int PRESCALE_W      = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  step,
    input  logic                  halt,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  enable,
    output logic                  running,
    output logic                  halted
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic [1:0]            state;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic                  step_src;
    logic                  step_d;
    logic                  step_rise;

`ifdef STEP_DEBOUNCE_EN
    // Synchronizer and filter reset high so a step held through reset
    // never looks like a fresh rising edge.
    logic       step_s1;
    logic       step_s2;
    logic       step_filt;
    logic [7:0] stab_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_s1   <= 1'b1;
            step_s2   <= 1'b1;
            step_filt <= 1'b1;
            stab_cnt  <= '0;
        end else begin
            step_s1 <= step;
            step_s2 <= step_s1;
            // stab_cnt counts consecutive samples that disagree with the
            // filtered value; any agreeing sample restarts the count.
            if (step_s2 == step_filt) begin
                stab_cnt <= '0;
            end else if (stab_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
                step_filt <= step_s2;
                stab_cnt  <= '0;
            end else begin
                stab_cnt <= stab_cnt + 8'd1;
            end
        end
    end

    assign step_src = step_filt;
`else
    assign step_src = step;
`endif

    assign step_rise = step_src & ~step_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            enable  <= 1'b0;
            pre_cnt <= '0;
            step_d  <= 1'b1;
        end else begin
            step_d <= step_src;
            if (halt) begin
                state   <= S_HALT;
                enable  <= 1'b0;
                pre_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        enable <= 1'b0;
                        // run takes precedence; a coincident step is dropped
                        if (run) begin
                            state   <= S_RUN;
                            pre_cnt <= '0;
                        end else if (step_rise) begin
                            state  <= S_STEP;
                            enable <= 1'b1;
                        end
                    end
                    S_STEP: begin
                        state  <= S_IDLE;
                        enable <= 1'b0;
                    end
                    S_RUN: begin
                        if (!run) begin
                            state   <= S_IDLE;
                            enable  <= 1'b0;
                            pre_cnt <= '0;
                        end else if (pre_cnt >= prescale) begin
                            // >= so a prescale lowered below pre_cnt fires
                            // immediately instead of wrapping around
                            enable  <= 1'b1;
                            pre_cnt <= '0;
                        end else begin
                            enable  <= 1'b0;
                            pre_cnt <= pre_cnt + 1'b1;
                        end
                    end
                    default: begin // S_HALT
                        enable <= 1'b0;
                        if (!run) state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign running = (state == S_RUN);
    assign halted  = (state == S_HALT);

endmodule

// File: tb/tb_count_enable_ctrl.sv
// -----------------------------------------------------------------------------
// tb_count_enable_ctrl
//   Directed bench for count_enable_ctrl with a small downstream 8-bit counter
//   standing in for b_counter. Inputs change and outputs are sampled 1 time
//   unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_count_enable_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       step;
    logic       halt;
    logic [7:0] prescale;
    logic       enable;
    logic       running;
    logic       halted;

    logic       cnt_clr;
    logic [7:0] cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    count_enable_ctrl #(.PRESCALE_W(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .step     (step),
        .halt     (halt),
        .prescale (prescale),
        .enable   (enable),
        .running  (running),
        .halted   (halted)
    );

    // downstream counter
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) cnt <= 8'h00;
        else if (enable)      cnt <= cnt + 8'h01;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  outs;
    logic [19:0] pat20;
    logic [5:0]  pat6;
    int          pulses;

    assign outs = {enable, running, halted};

    initial begin
        reset = 1'b1; run = 1'b0; step = 1'b1; halt = 1'b0;
        prescale = 8'd0; cnt_clr = 1'b0;

        // reset with step held high: no pulse afterwards
        tick(); tick();
        chk("reset_outs", 32'(outs), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_reset_outs", 32'(outs), 32'h0);
        end
        chk("post_reset_cnt", 32'(cnt), 32'h0);

        // single step: rise, held for 10 cycles
        step = 1'b0;
        tick();
        step = 1'b1;
        pulses = 0;
        tick();
        chk("step_first", 32'(enable), 32'h1);
        if (enable) pulses++;
        tick();
        chk("step_width", 32'(enable), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (enable) pulses++;
        end
        chk("step_pulses", 32'(pulses), 32'd1);
        chk("step_cnt", 32'(cnt), 32'h1);
        step = 1'b0;
        tick();

        // prescaled run, prescale=3
        prescale = 8'd3;
        run = 1'b1;
        tick();
        chk("run_entry", 32'(outs), 32'b010);
        pat20 = '0;
        pulses = 0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            pat20[j-1] = enable;
            if (enable) pulses++;
            // step ignored while running
            step = (j == 5);
        end
        chk("ps3_pattern", 32'(pat20), 32'h88888);
        chk("ps3_pulses", 32'(pulses), 32'd5);
        chk("ps3_running", 32'(running), 32'h1);
        run = 1'b0;
        step = 1'b0;
        tick();
        chk("run_release", 32'(outs), 32'b000);
        chk("ps3_cnt", 32'(cnt), 32'd6);

        // full-rate run with counter wrap
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        prescale = 8'd0;
        run = 1'b1;
        tick();
        chk("full_entry_en", 32'(enable), 32'h0);
        pulses = 0;
        for (int j = 1; j <= 256; j++) begin
            tick();
            if (enable) pulses++;
        end
        chk("full_pulses", 32'(pulses), 32'd256);
        chk("full_cnt_ff", 32'(cnt), 32'hFF);

        // halt mid-run with run held
        halt = 1'b1;
        tick();
        chk("halt_outs", 32'(outs), 32'b001);
        chk("full_cnt_wrap", 32'(cnt), 32'h00);
        halt = 1'b0;
        tick();
        chk("halt_hold1", 32'(outs), 32'b001);
        tick();
        chk("halt_hold2", 32'(outs), 32'b001);
        run = 1'b0;
        tick();
        chk("halt_exit", 32'(outs), 32'b000);
        tick();
        chk("halt_exit_idle", 32'(outs), 32'b000);
        chk("halt_cnt", 32'(cnt), 32'h00);

        // prescale change 10 -> 2 with pre_cnt at 7
        prescale = 8'd10;
        run = 1'b1;
        tick();
        pulses = 0;
        for (int j = 1; j <= 7; j++) begin
            tick();
            if (enable) pulses++;
        end
        chk("ps10_no_pulse", 32'(pulses), 32'd0);
        prescale = 8'd2;
        tick();
        chk("ps_change_fire", 32'(enable), 32'h1);
        pat6 = '0;
        for (int j = 0; j < 6; j++) begin
            tick();
            pat6[j] = enable;
        end
        chk("ps2_pattern", 32'(pat6), 32'b100100);

        // reset mid-run cuts operation at the next edge
        prescale = 8'd0;
        tick(); tick();
        chk("pre_reset_en", 32'(enable), 32'h1);
        reset = 1'b1;
        tick();
        chk("mid_reset_outs", 32'(outs), 32'b000);
        reset = 1'b0;
        run = 1'b0;
        step = 1'b0;
        tick();

        // run beats a simultaneous step rise in IDLE; step discarded
        run = 1'b1;
        step = 1'b1;
        tick();
        chk("run_wins", 32'(outs), 32'b010);
        run = 1'b0;
        tick();
        tick();
        chk("step_dropped", 32'(outs), 32'b000);

        // halt has priority over a step rise
        step = 1'b0;
        tick();
        step = 1'b1;
        halt = 1'b1;
        tick();
        chk("halt_over_step", 32'(outs), 32'b001);
        halt = 1'b0;
        tick();
        chk("halt_to_idle", 32'(outs), 32'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
